reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_scoreboard.sv | 45 ++++
 rtl/reg_file.sv | 81 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared CPU definitions: datapath widths and the hardwired-zero register index.
// Imported by the register file, ALU and control decode.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy scoreboard: one pending bit per register, set by lock, cleared by write.
// Lock wins over a same-index write; index 0 is never marked busy.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en && clr_addr != ZERO_IDX)
      busy_d[clr_addr] = 1'b0;
    // set after clear so a colliding lock leaves the bit pending
    if (set_en && set_addr != ZERO_IDX)
      busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy1 = busy_q[raddr1];
  assign busy2 = busy_q[raddr2];

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write register file with x0 hardwired to zero and busy lookup.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data into the reads.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic              sb_busy1;
  logic              sb_busy2;

  always_comb begin
    rf_d = rf_q;
    if (we && waddr != ZERO_IDX)
      rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rf_q <= '{default: '0};
    else
      rf_q <= rf_d;
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (lock_en),
    .set_addr(lock_addr),
    .clr_en  (we),
    .clr_addr(waddr),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .busy1   (sb_busy1),
    .busy2   (sb_busy2)
  );

`ifdef REG_FILE_BYPASS_EN
  logic wr_live;
  logic fwd1;
  logic fwd2;

  // no forwarding while held in reset: the write is being discarded
  assign wr_live = rst_n && we && waddr != ZERO_IDX;
  assign fwd1    = wr_live && waddr == raddr1;
  assign fwd2    = wr_live && waddr == raddr2;

  assign rdata1 = fwd1 ? wdata : rf_q[raddr1];
  assign rdata2 = fwd2 ? wdata : rf_q[raddr2];
  assign busy1  = fwd1 ? 1'b0 : sb_busy1;
  assign busy2  = fwd2 ? 1'b0 : sb_busy2;
`else
  assign rdata1 = rf_q[raddr1];
  assign rdata2 = rf_q[raddr2];
  assign busy1  = sb_busy1;
  assign busy2  = sb_busy2;
`endif

endmodule
